// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel push-button debouncer.
// Holds the per-channel FSM encoding, a counter-width helper and the synchroniser idle value.
package debounce_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED     = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_LONG_HELD    = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } btn_state_e;

    // Value the synchronisers take in reset: button not pressed.
    localparam logic SYNC_INACTIVE = 1'b0;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF synchroniser, stability/long-hold counters and the debounce FSM.
// The FSM only advances on prescaler ticks; all outputs are registered.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 200,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_hit
);

    localparam int SW = cnt_width(STABLE_TICKS + 1);
    localparam int LW = cnt_width(LONG_TICKS + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);
    localparam bit            FAST      = (STABLE_TICKS == 1);

    logic sync_q1;
    logic s;

    // NOTE: non-blocking assignments keep the two flops as a real two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= SYNC_INACTIVE;
            s       <= SYNC_INACTIVE;
        end else begin
            sync_q1 <= raw ^ ACTIVE_LOW;
            s       <= sync_q1;
        end
    end

    btn_state_e    state, state_d;
    logic [SW-1:0] stab_cnt, stab_d;
    logic [LW-1:0] long_cnt, long_d;
    logic          long_done, long_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RELEASED;
            stab_cnt  <= '0;
            long_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            state     <= state_d;
            stab_cnt  <= stab_d;
            long_cnt  <= long_d;
            long_done <= long_done_d;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state;
        stab_d      = stab_cnt;
        long_d      = long_cnt;
        long_done_d = long_done;

        if (tick) begin
            // Hold time keeps accumulating while the debounced level is 1, saturating.
            if ((state inside {ST_PRESSED, ST_LONG_HELD, ST_RELEASE_WAIT}) &&
                (long_cnt != LONG_MAX)) begin
                long_d = long_cnt + 1'b1;
            end

            unique case (state)
                ST_RELEASED: begin
                    if (s) begin
                        if (FAST) begin
                            state_d = ST_PRESSED;
                            stab_d  = '0;
                            long_d  = '0;
                        end else begin
                            state_d = ST_PRESS_WAIT;
                            stab_d  = STAB_ONE;
                        end
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_d = ST_RELEASED;
                        stab_d  = '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state_d = ST_PRESSED;
                        stab_d  = '0;
                        long_d  = '0;
                    end else begin
                        stab_d = stab_cnt + 1'b1;
                    end
                end

                ST_PRESSED, ST_LONG_HELD: begin
                    if (!s) begin
                        if (FAST) begin
                            state_d     = ST_RELEASED;
                            stab_d      = '0;
                            long_done_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                            stab_d  = STAB_ONE;
                        end
                    end else if ((state == ST_PRESSED) && (long_cnt >= LONG_LAST)) begin
                        state_d     = ST_LONG_HELD;
                        long_done_d = 1'b1;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state_d = long_done ? ST_LONG_HELD : ST_PRESSED;
                        stab_d  = '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state_d     = ST_RELEASED;
                        stab_d      = '0;
                        long_done_d = 1'b0;
                    end else begin
                        stab_d = stab_cnt + 1'b1;
                    end
                end

                default: begin
                    state_d = ST_RELEASED;
                    stab_d  = '0;
                end
            endcase
        end
    end

    logic level_d, press_d, rel_d, long_hit_d;

    // Pulses are decoded from the transition the FSM is about to take.
    always_comb begin
        press_d    = (state inside {ST_RELEASED, ST_PRESS_WAIT}) && (state_d == ST_PRESSED);
        rel_d      = (state inside {ST_PRESSED, ST_LONG_HELD, ST_RELEASE_WAIT}) &&
                     (state_d == ST_RELEASED);
        long_hit_d = (state == ST_PRESSED) && (state_d == ST_LONG_HELD);
        level_d    = state_d inside {ST_PRESSED, ST_LONG_HELD, ST_RELEASE_WAIT};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= 1'b0;
            press    <= 1'b0;
            rel      <= 1'b0;
            long_hit <= 1'b0;
        end else begin
            level    <= level_d;
            press    <= press_d;
            rel      <= rel_d;
            long_hit <= long_hit_d;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: one shared tick prescaler feeding CH independent
// debounce channels that report a clean level plus press, release and long-press pulses.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CH           = 4,
    parameter int DIV_TIMES    = 100,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 200,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] pb_in,
    output logic [CH-1:0] pb_level,
    output logic [CH-1:0] pb_press,
    output logic [CH-1:0] pb_release,
    output logic [CH-1:0] pb_long,
    output logic          tick
);

    localparam int PW = cnt_width(DIV_TIMES);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV_TIMES - 1);

    logic [PW-1:0] div_cnt;

    // Tick is an enable strobe for the channel FSMs, never used as a clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .raw     (pb_in[i]),
            .level   (pb_level[i]),
            .press   (pb_press[i]),
            .rel     (pb_release[i]),
            .long_hit(pb_long[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: an active-high and an active-low instance driven by directed
// scenarios then random bouncing, compared every cycle against a run-length reference model.
module tb_debounce_multi;

    localparam int CH     = 2;
    localparam int DIV    = 4;
    localparam int STABLE = 3;
    localparam int LONG   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pb;
    logic [1:0] pb_al;

    logic [1:0] level_o [2];
    logic [1:0] press_o [2];
    logic [1:0] rel_o   [2];
    logic [1:0] long_o  [2];
    logic       tick_o  [2];

    always #5 clk = ~clk;

    debounce_multi #(
        .CH(CH), .DIV_TIMES(DIV), .STABLE_TICKS(STABLE), .LONG_TICKS(LONG), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pb_in(pb),
        .pb_level(level_o[0]), .pb_press(press_o[0]), .pb_release(rel_o[0]),
        .pb_long(long_o[0]), .tick(tick_o[0])
    );

    debounce_multi #(
        .CH(CH), .DIV_TIMES(DIV), .STABLE_TICKS(STABLE), .LONG_TICKS(LONG), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .pb_in(pb_al),
        .pb_level(level_o[1]), .pb_press(press_o[1]), .pb_release(rel_o[1]),
        .pb_long(long_o[1]), .tick(tick_o[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per channel, the committed level, how many consecutive ticks the
    // synchronised input has disagreed with it, and how many ticks the level has been 1.
    int         m_pcount;
    logic [1:0] m_s1 [2];
    logic [1:0] m_s2 [2];
    bit         m_level [2][2];
    int         m_run   [2][2];
    int         m_held  [2][2];
    bit         m_ldone [2][2];
    logic [1:0] e_level [2];
    logic [1:0] e_press [2];
    logic [1:0] e_rel   [2];
    logic [1:0] e_long  [2];
    logic       e_tick;

    int cnt_press [2][2];
    int cnt_rel   [2][2];
    int cnt_long  [2][2];
    int cyc       = 0;
    int last_tick = -1;
    bit seen_both = 1'b0;
    int hold_rem  [2][2];

    task automatic model_edge();
        bit   tick_now;
        bit   s;
        int   run_before;
        int   held_before;
        logic [1:0] raw;
        if (rst) begin
            m_pcount = 0;
            e_tick   = 1'b0;
            for (int u = 0; u < 2; u++) begin
                m_s1[u] = 2'b00; m_s2[u] = 2'b00;
                e_level[u] = 2'b00; e_press[u] = 2'b00; e_rel[u] = 2'b00; e_long[u] = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    m_level[u][c] = 1'b0; m_run[u][c] = 0; m_held[u][c] = 0; m_ldone[u][c] = 1'b0;
                end
            end
        end else begin
            tick_now = (m_pcount == DIV - 1);
            m_pcount = (m_pcount + 1) % DIV;
            e_tick   = (m_pcount == DIV - 1);
            for (int u = 0; u < 2; u++) begin
                for (int c = 0; c < 2; c++) begin
                    e_press[u][c] = 1'b0; e_rel[u][c] = 1'b0; e_long[u][c] = 1'b0;
                    if (tick_now) begin
                        s           = m_s2[u][c];
                        run_before  = m_run[u][c];
                        held_before = m_held[u][c];
                        if (m_level[u][c] && m_held[u][c] < LONG) m_held[u][c]++;
                        if (s != m_level[u][c]) begin
                            m_run[u][c]++;
                            if (m_run[u][c] == STABLE) begin
                                m_level[u][c] = s;
                                m_run[u][c]   = 0;
                                if (s) begin
                                    e_press[u][c] = 1'b1;
                                    m_held[u][c]  = 0;
                                end else begin
                                    e_rel[u][c]   = 1'b1;
                                    m_ldone[u][c] = 1'b0;
                                end
                            end
                        end else begin
                            if (m_level[u][c] && run_before == 0 && !m_ldone[u][c] &&
                                held_before >= LONG - 1) begin
                                e_long[u][c]  = 1'b1;
                                m_ldone[u][c] = 1'b1;
                            end
                            m_run[u][c] = 0;
                        end
                    end
                    e_level[u][c] = m_level[u][c];
                end
                raw     = (u == 0) ? pb : ~pb_al;
                m_s2[u] = m_s1[u];
                m_s1[u] = raw;
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            if (rst) last_tick = -1;
            @(negedge clk);
            cyc++;
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d level", u), level_o[u], e_level[u]);
                check($sformatf("u%0d press", u), press_o[u], e_press[u]);
                check($sformatf("u%0d release", u), rel_o[u], e_rel[u]);
                check($sformatf("u%0d long", u), long_o[u], e_long[u]);
                check($sformatf("u%0d tick", u), {1'b0, tick_o[u]}, {1'b0, e_tick});
                for (int c = 0; c < 2; c++) begin
                    cnt_press[u][c] += int'(press_o[u][c] === 1'b1);
                    cnt_rel[u][c]   += int'(rel_o[u][c] === 1'b1);
                    cnt_long[u][c]  += int'(long_o[u][c] === 1'b1);
                end
            end
            if (press_o[0] === 2'b11) seen_both = 1'b1;
            if (tick_o[0] === 1'b1) begin
                if (last_tick >= 0) check_int("tick period", cyc - last_tick, DIV);
                last_tick = cyc;
            end
        end
    endtask

    initial begin
        int p0, r0;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
                cnt_press[u][c] = 0; cnt_rel[u][c] = 0; cnt_long[u][c] = 0; hold_rem[u][c] = 0;
            end

        // Reset with both buttons held; outputs must be 0 throughout.
        rst = 1'b1; pb = 2'b11; pb_al = 2'b11;
        step(3);
        check("reset level", level_o[0], 2'b00);
        check("reset tick", {1'b0, tick_o[0]}, 2'b00);
        rst = 1'b0;

        // Held since reset: simultaneous press, then one long pulse per channel.
        step(80);
        check_int("press together", int'(seen_both), 1);
        check_int("press ch0 once", cnt_press[0][0], 1);
        check_int("press ch1 once", cnt_press[0][1], 1);
        check_int("long ch1 once", cnt_long[0][1], 1);
        check_int("long ch0 once", cnt_long[0][0], 1);

        // Release ch1 cleanly.
        pb[1] = 1'b0;
        step(24);
        check_int("release ch1", cnt_rel[0][1], 1);
        check("level after release", level_o[0], 2'b01);
        check_int("no second long ch1", cnt_long[0][1], 1);

        // Two-tick dropout on ch0 while long-held: no release, no new long.
        pb[0] = 1'b0; step(8);
        pb[0] = 1'b1; step(40);
        check_int("dropout no release", cnt_rel[0][0], 0);
        check_int("dropout no long", cnt_long[0][0], 1);
        check_int("dropout no press", cnt_press[0][0], 1);

        // Three-tick drop commits the release.
        pb[0] = 1'b0; step(20);
        check_int("release ch0", cnt_rel[0][0], 1);
        check("level both low", level_o[0], 2'b00);

        // Bounce: 2 ticks high, 1 low, then steady high.
        p0 = cnt_press[0][0];
        pb[0] = 1'b1; step(8);
        pb[0] = 1'b0; step(4);
        check_int("bounce no press", cnt_press[0][0] - p0, 0);
        pb[0] = 1'b1; step(20);
        check_int("bounce single press", cnt_press[0][0] - p0, 1);

        // Reset while ch0 is pressed: level drops, no release, fresh press later.
        p0 = cnt_press[0][0]; r0 = cnt_rel[0][0];
        rst = 1'b1; step(1);
        rst = 1'b0;
        check("level after reset", level_o[0], 2'b00);
        step(24);
        check_int("reset no release", cnt_rel[0][0] - r0, 0);
        check_int("reset re-press", cnt_press[0][0] - p0, 1);

        // Active-low instance: idle high produced nothing; driving low presses.
        check_int("al idle ch0", cnt_press[1][0], 0);
        check_int("al idle ch1", cnt_press[1][1], 0);
        pb_al = 2'b10; step(20);
        check_int("al press ch0", cnt_press[1][0], 1);
        check_int("al ch1 quiet", cnt_press[1][1], 0);
        pb_al = 2'b11; step(20);
        check_int("al release ch0", cnt_rel[1][0], 1);

        // Random bouncing on all channels of both instances.
        for (int k = 0; k < 700; k++) begin
            for (int u = 0; u < 2; u++)
                for (int c = 0; c < 2; c++) begin
                    if (hold_rem[u][c] == 0) begin
                        if (u == 0) pb[c] = ~pb[c];
                        else        pb_al[c] = ~pb_al[c];
                        hold_rem[u][c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                                                     : int'($urandom_range(12, 60));
                    end else begin
                        hold_rem[u][c]--;
                    end
                end
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner for board-level inputs.
- Replaces the single-channel shift-register debouncer with:
  - a shared tick prescaler;
  - per-channel 2-FF synchroniser, stability counter and FSM;
  - registered clean level plus one-clock press, release and long-press pulses.
- Sits between raw pad inputs and user control logic.

Parameters:
- CH, 4: number of independent button channels.
- DIV_TIMES, 100: clk cycles per sample tick (>=2).
- STABLE_TICKS, 4: consecutive ticks a new value must persist before commit (>=1).
- LONG_TICKS, 200: ticks the debounced level must stay 1 before pb_long fires (>STABLE_TICKS).
- ACTIVE_LOW, 0: 1 = raw input is active-low; inverted before the synchroniser.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- pb_in  input  CH  raw asynchronous button inputs.
- pb_level  output  CH  debounced level, 1 = pressed.
- pb_press  output  CH  one-clk pulse on debounced 0->1.
- pb_release  output  CH  one-clk pulse on debounced 1->0.
- pb_long  output  CH  one-clk pulse when held LONG_TICKS ticks.
- tick  output  1  prescaler strobe, for observation.

Behaviour:
- Reset (rst=1 at posedge clk):
  - prescaler count=0, tick=0;
  - synchronisers=0 (inactive);
  - all FSMs go to RELEASED with counters 0;
  - every output is 0 from the following cycle.
- Prescaler: count 0..DIV_TIMES-1, wraps to 0. tick=1 for exactly one clk when count==DIV_TIMES-1. It is a strobe, not a toggled clock; there is no derived clock anywhere.
- Input path: s_raw = pb_in ^ {CH{ACTIVE_LOW}}. Two flops run every clk. The FSM uses only the second-stage value s.
- Per-channel FSM: evaluates only on cycles with tick=1 and holds otherwise. States: RELEASED, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
  - RELEASED:
    - s=1 and STABLE_TICKS==1 -> commit press;
    - s=1 otherwise -> PRESS_WAIT, stab_cnt=1.
  - PRESS_WAIT:
    - s=0 -> RELEASED, stab_cnt=0 (bounce rejected, no pulse);
    - s=1 and stab_cnt==STABLE_TICKS-1 -> commit press;
    - else stab_cnt++.
  - Commit press: PRESSED, level=1, press pulse, stab_cnt=0, long_cnt=0.
  - PRESSED/LONG_HELD:
    - s=0 -> RELEASE_WAIT, stab_cnt=1 (or commit release immediately if STABLE_TICKS==1);
    - in PRESSED with s=1: long_cnt++; when long_cnt reaches LONG_TICKS-1 -> LONG_HELD, long pulse.
  - RELEASE_WAIT:
    - s=1 -> return to PRESSED or LONG_HELD (long_done flag selects), stab_cnt=0;
    - s=0 and stab_cnt==STABLE_TICKS-1 -> commit release;
    - else stab_cnt++.
    - long_cnt keeps counting during RELEASE_WAIT.
  - Commit release: RELEASED, level=0, release pulse, long_done=0.
- pb_long fires at most once per press. A bounce in RELEASE_WAIT never re-fires press or long.
- Outputs are registered. Pulses are high in the clk cycle after the committing tick, one clk wide. pb_level changes in that same cycle.
- Latency: from a clean stable edge at pb_in to pb_press is 2 clk + (STABLE_TICKS-1)*DIV_TIMES + wait-to-first-tick + 1 clk. Max = 3 + STABLE_TICKS*DIV_TIMES clk.
- Widths: prescaler $clog2(DIV_TIMES); stab_cnt $clog2(STABLE_TICKS+1); long_cnt $clog2(LONG_TICKS+1). long_cnt saturates and never wraps.
- Channels are fully independent. Simultaneous commits on several channels all pulse in the same cycle.
- Reset mid-press: outputs drop next cycle and no release pulse is emitted. A button still held after reset deasserts is re-detected as a fresh press after STABLE_TICKS ticks.

Decomposition:
- Package debounce_pkg holds:
  - FSM state typedef (3-bit encoding for the five states);
  - clog2-based width helper;
  - a reset-inactive constant.
- Sub-module debounce_ch: synchroniser, FSM and counters for one channel. Instantiated CH times via generate.
- The prescaler stays inline in debounce_multi.

Test Plan:
Bench: CH=2, DIV_TIMES=4, STABLE_TICKS=3, LONG_TICKS=10, ACTIVE_LOW=0.
- Reset: rst high 3 clk with pb_in=2'b11 -> all outputs 0 during reset. After release, ch0/ch1 pb_press fire together after 3 ticks; tick period is exactly 4 clk.
- Bounce rejection: ch0 high for 2 ticks, low 1 tick, high again -> single pb_press only after 3 consecutive high ticks; no pulse on the glitch.
- Long press: hold ch1 for 12 ticks -> pb_press once, pb_long once at tick 10 after commit, never again. Release -> one pb_release and pb_level=0.
- Release bounce: from LONG_HELD drop ch0 for 2 ticks then high -> no release, no second long. Drop for 3 ticks -> one release.
- Reset mid-press: ch0 PRESSED, pulse rst 1 clk with pb_in held -> pb_level=0 next clk, no release pulse, fresh pb_press 3 ticks later.
- ACTIVE_LOW=1 rerun: pb_in idle 2'b11 -> no pulses. Drive 0 for 3 ticks -> pb_press.
